serial_port_arbiter: RTL and testbench



---
 rtl/serial_port_arbiter_if.sv | 41 ++++
 rtl/serial_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_serial_port_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_port_arbiter_if.sv
// Bundle between the arbiter, the two byte requesters,
// the rx consumer and the serial device mem port.
interface serial_port_arbiter_if #(
  parameter int ADDR_W = 18
);
  logic              req0Valid;
  logic [7:0]        req0Data;
  logic              req0Ready;
  logic              req1Valid;
  logic [7:0]        req1Data;
  logic              req1Ready;
  logic              rxValid;
  logic [7:0]        rxData;
  logic              rxReady;
  logic              memClkEn;
  logic              memWE;
  logic [ADDR_W-1:0] memAddr;
  logic [31:0]       memData;
  logic [31:0]       memQ;
  logic              lastGrant;

  modport master (
    input  req0Valid, req0Data,
    input  req1Valid, req1Data,
    input  rxReady, memQ,
    output req0Ready, req1Ready,
    output rxValid, rxData,
    output memClkEn, memWE, memAddr, memData,
    output lastGrant
  );

  modport slave (
    output req0Valid, req0Data,
    output req1Valid, req1Data,
    output rxReady, memQ,
    input  req0Ready, req1Ready,
    input  rxValid, rxData,
    input  memClkEn, memWE, memAddr, memData,
    input  lastGrant
  );
endinterface

// File: rtl/serial_port_arbiter.sv
// Polls the serial device flags, drains rx bytes into a
// one-entry buffer and shares tx between two requesters.
module serial_port_arbiter #(
  parameter int ADDR_W     = 18,
  parameter int TX_ADDR    = 0,
  parameter int RX_ADDR    = 1,
  parameter int FLAGS_ADDR = 2,
  parameter int RD_LAT     = 1
) (
  input logic clk,
  input logic rst,
  serial_port_arbiter_if.master bus
);
  localparam logic [ADDR_W-1:0] TxA = ADDR_W'(TX_ADDR);
  localparam logic [ADDR_W-1:0] RxA = ADDR_W'(RX_ADDR);
  localparam logic [ADDR_W-1:0] FlA = ADDR_W'(FLAGS_ADDR);

  typedef enum logic [2:0] {
    IDLE, POLL, RX_RD, RX_WAIT, TX_WR
  } state_t;

  state_t state, stateN;
  logic [1:0] cnt, cntN;
  logic rr, rrN, pref, prefN, grant, grantN;
  logic strobe, strobeN, writeEn, writeEnN;
  logic [ADDR_W-1:0] addr, addrN;
  logic [7:0] txByte, txByteN, rxByte, rxByteN;
  logic ready0, ready0N, ready1, ready1N;
  logic rxFull, rxFullN, lastId, lastIdN;
  logic rxWant, txWant, grantSel;
  logic unusedQ;

  assign unusedQ  = ^bus.memQ[31:8];
  assign rxWant   = ~bus.memQ[2] & ~rxFull;
  assign txWant   = ~bus.memQ[0] &
                    (bus.req0Valid | bus.req1Valid);
  assign grantSel = (bus.req0Valid & bus.req1Valid) ?
                    rr : bus.req1Valid;

  always_comb begin
    stateN   = state;
    cntN     = cnt;
    rrN      = rr;
    prefN    = pref;
    grantN   = grant;
    strobeN  = 1'b0;
    writeEnN = 1'b0;
    addrN    = addr;
    txByteN  = txByte;
    rxByteN  = rxByte;
    ready0N  = 1'b0;
    ready1N  = 1'b0;
    rxFullN  = rxFull & ~bus.rxReady;
    lastIdN  = lastId;
    unique case (state)
      IDLE: begin
        addrN  = FlA;
        stateN = POLL;
      end
      POLL: begin
        if (rxWant && (pref || !txWant)) begin
          addrN   = RxA;
          strobeN = 1'b1;
          stateN  = RX_RD;
        end else if (txWant) begin
          grantN   = grantSel;
          txByteN  = grantSel ? bus.req1Data
                              : bus.req0Data;
          addrN    = TxA;
          strobeN  = 1'b1;
          writeEnN = 1'b1;
          ready0N  = ~grantSel;
          ready1N  = grantSel;
          stateN   = TX_WR;
        end else begin
          stateN = IDLE;
        end
      end
      RX_RD: begin
        cntN   = 2'(RD_LAT - 1);
        stateN = RX_WAIT;
      end
      RX_WAIT: begin
        // memQ is valid for the pop only in the last wait cycle
        if (cnt == 2'd0) begin
          rxByteN = bus.memQ[7:0];
          rxFullN = 1'b1;
          prefN   = 1'b0;
          addrN   = FlA;
          stateN  = IDLE;
        end else begin
          cntN = cnt - 2'd1;
        end
      end
      TX_WR: begin
        lastIdN = grant;
        rrN     = ~grant;
        prefN   = 1'b1;
        addrN   = FlA;
        stateN  = IDLE;
      end
      default: stateN = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      rr      <= 1'b0;
      pref    <= 1'b1;
      grant   <= 1'b0;
      strobe  <= 1'b0;
      writeEn <= 1'b0;
      addr    <= FlA;
      txByte  <= 8'd0;
      rxByte  <= 8'd0;
      ready0  <= 1'b0;
      ready1  <= 1'b0;
      rxFull  <= 1'b0;
      lastId  <= 1'b0;
    end else begin
      state   <= stateN;
      cnt     <= cntN;
      rr      <= rrN;
      pref    <= prefN;
      grant   <= grantN;
      strobe  <= strobeN;
      writeEn <= writeEnN;
      addr    <= addrN;
      txByte  <= txByteN;
      rxByte  <= rxByteN;
      ready0  <= ready0N;
      ready1  <= ready1N;
      rxFull  <= rxFullN;
      lastId  <= lastIdN;
    end
  end

  assign bus.memClkEn  = strobe;
  assign bus.memWE     = writeEn;
  assign bus.memAddr   = addr;
  assign bus.memData   = {24'd0, txByte};
  assign bus.req0Ready = ready0;
  assign bus.req1Ready = ready1;
  assign bus.rxValid   = rxFull;
  assign bus.rxData    = rxByte;
  assign bus.lastGrant = lastId;
endmodule

// File: tb/tb_serial_port_arbiter.sv
// Scoreboard bench: stimulus queues expected device ops and
// rx bytes; a negedge monitor pops and compares them.
module tb_serial_port_arbiter;
  localparam int ADDR_W = 18;
  localparam int RD_LAT = 1;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        r0;
    logic        r1;
    logic        chkLg;
    logic        lg;
  } op_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_port_arbiter_if #(.ADDR_W(ADDR_W)) bus();

  serial_port_arbiter #(
    .ADDR_W(ADDR_W),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  logic [2:0] flags;
  logic [7:0] rxBase;
  logic [7:0] popCnt = 8'd0;
  logic [7:0] rdData = 8'd0;

  // device model: flags register plus a counting rx FIFO
  assign bus.memQ =
    (bus.memAddr == ADDR_W'(2)) ? {29'd0, flags} :
    (bus.memAddr == ADDR_W'(1)) ? {24'd0, rdData} :
    32'd0;

  always @(posedge clk)
    if (bus.memClkEn && !bus.memWE &&
        bus.memAddr == ADDR_W'(1)) begin
      rdData <= rxBase + popCnt;
      popCnt <= popCnt + 8'd1;
    end

  op_t expQ[$];
  logic [7:0] expRx[$];
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int opsSeen = 0;
  int writesSeen = 0;
  int r1Seen = 0;
  int lastStrobeCyc = 0;
  logic lgPending = 1'b0;
  logic lgExp = 1'b0;
  op_t monE;
  logic [7:0] monRx;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (lgPending) begin
      check("lastGrant", 32'(bus.lastGrant), 32'(lgExp));
      lgPending = 1'b0;
    end
    if (bus.memClkEn) begin
      opsSeen++;
      lastStrobeCyc = cyc;
      if (bus.memWE) writesSeen++;
      if (bus.req1Ready) r1Seen++;
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected strobe: we=%b addr=%0d",
                 bus.memWE, bus.memAddr);
      end else begin
        monE = expQ.pop_front();
        check("op.we", 32'(bus.memWE), 32'(monE.we));
        check("op.addr", 32'(bus.memAddr), monE.addr);
        if (monE.we)
          check("op.data", bus.memData, monE.data);
        check("op.ready0", 32'(bus.req0Ready), 32'(monE.r0));
        check("op.ready1", 32'(bus.req1Ready), 32'(monE.r1));
        if (monE.we && monE.chkLg) begin
          lgPending = 1'b1;
          lgExp = monE.lg;
        end
      end
    end else if (bus.req0Ready || bus.req1Ready) begin
      compared++;
      mismatched++;
      $display("FAIL stray ready: r0=%b r1=%b",
               bus.req0Ready, bus.req1Ready);
    end
    if (bus.rxValid && bus.rxReady) begin
      if (expRx.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected rx byte: got %h",
                 bus.rxData);
      end else begin
        monRx = expRx.pop_front();
        check("rxData", 32'(bus.rxData), 32'(monRx));
      end
    end
  end

  function automatic op_t rdOp();
    op_t o;
    o = '{we: 1'b0, addr: 32'd1, data: 32'd0,
          r0: 1'b0, r1: 1'b0, chkLg: 1'b0, lg: 1'b0};
    return o;
  endfunction

  function automatic op_t wrOp(logic [7:0] d, logic id,
                               logic chk);
    op_t o;
    o = '{we: 1'b1, addr: 32'd0, data: {24'd0, d},
          r0: ~id, r1: id, chkLg: chk, lg: id};
    return o;
  endfunction

  task automatic idleInputs();
    bus.req0Valid = 1'b0;
    bus.req1Valid = 1'b0;
    bus.req0Data  = 8'd0;
    bus.req1Data  = 8'd0;
    bus.rxReady   = 1'b0;
    flags = 3'b100;
  endtask

  task automatic doReset();
    idleInputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic waitWrites(int target, string name);
    int n = 0;
    while (writesSeen < target && n < 60) begin
      @(negedge clk);
      #1 n++;
    end
    if (writesSeen < target)
      check(name, 32'(writesSeen), 32'(target));
  endtask

  task automatic waitOps(int target, string name);
    int n = 0;
    while (opsSeen < target && n < 80) begin
      @(negedge clk);
      #1 n++;
    end
    if (opsSeen < target)
      check(name, 32'(opsSeen), 32'(target));
  endtask

  task automatic waitRxValid(string name);
    int n = 0;
    while (!bus.rxValid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rxValid) check(name, 32'd0, 32'd1);
  endtask

  initial begin
    int base;
    int k;
    int n;
    rxBase = 8'd0;
    idleInputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.memClkEn", 32'(bus.memClkEn), 32'd0);
    check("rst.memWE", 32'(bus.memWE), 32'd0);
    check("rst.memAddr", 32'(bus.memAddr), 32'd2);
    check("rst.memData", bus.memData, 32'd0);
    check("rst.ready", {30'd0, bus.req1Ready, bus.req0Ready}, 32'd0);
    check("rst.rxValid", 32'(bus.rxValid), 32'd0);
    check("rst.rxData", 32'(bus.rxData), 32'd0);
    check("rst.lastGrant", 32'(bus.lastGrant), 32'd0);
    rst = 1'b0;

    // rx path with a single byte and no consumer
    doReset();
    rxBase = 8'h41 - popCnt;
    expQ.push_back(rdOp());
    flags = 3'b000;
    waitRxValid("rx1.timeout");
    if (bus.rxValid)
      check("rx1.latency", 32'(cyc - lastStrobeCyc),
            32'(RD_LAT + 1));
    repeat (20) @(posedge clk);
    #1;
    check("rx1.held", 32'(bus.rxValid), 32'd1);
    check("rx1.data", 32'(bus.rxData), 32'h41);
    flags = 3'b100;
    expRx.push_back(8'h41);
    bus.rxReady = 1'b1;
    @(posedge clk);
    #1 bus.rxReady = 1'b0;
    check("rx1.cleared", 32'(bus.rxValid), 32'd0);

    // single requester
    doReset();
    expQ.push_back(wrOp(8'h55, 1'b0, 1'b1));
    bus.req0Data  = 8'h55;
    bus.req0Valid = 1'b1;
    base = writesSeen;
    waitWrites(base + 1, "tx1.timeout");
    @(posedge clk);
    #1 bus.req0Valid = 1'b0;
    repeat (4) @(posedge clk);

    // both requesters contend
    doReset();
    for (int i = 0; i < 4; i++)
      expQ.push_back(wrOp(i[0] ? 8'hB1 : 8'hA0, i[0], 1'b1));
    bus.req0Data  = 8'hA0;
    bus.req1Data  = 8'hB1;
    bus.req0Valid = 1'b1;
    bus.req1Valid = 1'b1;
    base = writesSeen;
    waitWrites(base + 4, "tx2.timeout");
    @(posedge clk);
    #1;
    bus.req0Valid = 1'b0;
    bus.req1Valid = 1'b0;
    repeat (4) @(posedge clk);

    // tx FIFO full holds the requester off
    doReset();
    flags = 3'b101;
    bus.req1Data  = 8'h3C;
    bus.req1Valid = 1'b1;
    base = writesSeen;
    k = r1Seen;
    repeat (20) @(posedge clk);
    #1;
    check("full.noWrite", 32'(writesSeen - base), 32'd0);
    check("full.noReady", 32'(r1Seen - k), 32'd0);
    expQ.push_back(wrOp(8'h3C, 1'b1, 1'b1));
    flags = 3'b100;
    k = cyc;
    waitWrites(base + 1, "full.timeout");
    if (writesSeen > base)
      check("full.resume<=3", 32'((lastStrobeCyc - k) <= 3),
            32'd1);
    @(posedge clk);
    #1 bus.req1Valid = 1'b0;
    repeat (4) @(posedge clk);

    // rx and tx both wanted: strict alternation
    doReset();
    rxBase = 8'h30 - popCnt;
    for (int i = 0; i < 3; i++) begin
      expQ.push_back(rdOp());
      expQ.push_back(wrOp(8'h77, 1'b0, 1'b1));
      expRx.push_back(8'(8'h30 + i));
    end
    flags = 3'b000;
    bus.rxReady   = 1'b1;
    bus.req0Data  = 8'h77;
    bus.req0Valid = 1'b1;
    base = opsSeen;
    waitOps(base + 6, "alt.timeout");
    @(posedge clk);
    #1;
    bus.req0Valid = 1'b0;
    flags = 3'b100;
    repeat (4) @(posedge clk);
    #1 bus.rxReady = 1'b0;

    // reset during a write with a byte in the rx buffer
    doReset();
    rxBase = 8'hE0 - popCnt;
    expQ.push_back(rdOp());
    flags = 3'b000;
    waitRxValid("rst.rxTimeout");
    flags = 3'b100;
    expQ.push_back(wrOp(8'h99, 1'b0, 1'b0));
    bus.req0Data  = 8'h99;
    bus.req0Valid = 1'b1;
    n = 0;
    while (!bus.memWE && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst.sawWrite", 32'(bus.memWE), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst.asyncClkEn", 32'(bus.memClkEn), 32'd0);
    check("rst.asyncWE", 32'(bus.memWE), 32'd0);
    check("rst.asyncReady", 32'(bus.req0Ready), 32'd0);
    bus.req0Valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst.addr", 32'(bus.memAddr), 32'd2);
    check("rst.rxDropped", 32'(bus.rxValid), 32'd0);
    check("rst.lastGrant2", 32'(bus.lastGrant), 32'd0);
    repeat (6) @(posedge clk);

    #1;
    check("expQ.drained", 32'(expQ.size()), 32'd0);
    check("expRx.drained", 32'(expRx.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
